// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation
// encodings, FSM states and small operation-class helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MADDU = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_BUSY   = 2'd1,
    MD_FINISH = 2'd2
  } md_state_e;

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_seq_unit_if.sv
// Execute-stage handshake and HI/LO result bus of the multiply/divide unit.
interface muldiv_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  muldiv_pkg::md_op_e op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               flush;
  logic               ready;
  logic               busy;
  logic               done;
  logic               div_by_zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output start, op, a, b, flush,
    input  ready, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output ready, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath on {acc, q}: shift-add multiply
// step (right shift) or restoring-division step (left shift).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    sum       = {1'b0, acc} + {1'b0, m};
    rem_shift = {acc, q[WIDTH-1]};
    diff      = rem_shift - {1'b0, m};
    acc_next  = acc;
    q_next    = q;
    if (is_div) begin
      // acc < divisor always holds, so diff[WIDTH] is a clean borrow flag
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_shift[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else if (q[0]) begin
      {acc_next, q_next} = {sum, q[WIDTH-1:1]};
    end else begin
      {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and start/busy/done
// handshake. Define MULDIV_MADD_EN to enable MADD/MADDU accumulate ops.
module muldiv_seq_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  muldiv_seq_unit_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  md_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt;
  md_op_e           op_in, op_r;
  logic             accept_iter, accept_dbz, wr_hi, wr_lo, wr_nop;
  logic             finish_wr, step_en, last_iter, signed_op;
  logic [WIDTH-1:0] acc, q, m, acc_step, q_step;
  logic             neg_q, neg_r, dbz_r;
  logic [WIDTH-1:0] hi, lo, quot_fix, rem_fix;
  logic [W2-1:0]    prod_fix;
  logic             done, dbz_flag;
  logic signed [WIDTH-1:0] a_s, b_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v, input logic en);
    return en ? (~v + W2'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic en);
    return neg_w(v, en & v[WIDTH-1]);
  endfunction

  assign op_in     = bus.op;
  assign a_s       = bus.a;
  assign b_s       = bus.b;
  assign signed_op = is_signed_op(op_in);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept_iter || accept_dbz) cnt <= '0;
      else if (step_en)              cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx    = state;
    accept_iter = 1'b0;
    accept_dbz  = 1'b0;
    wr_hi       = 1'b0;
    wr_lo       = 1'b0;
    wr_nop      = 1'b0;
    finish_wr   = 1'b0;
    step_en     = 1'b0;
    case (state)
      MD_IDLE: begin
        // a flush in the same cycle squashes the request outright
        if (bus.start && !bus.flush) begin
          case (op_in)
            MD_MULT, MD_MULTU: begin
              accept_iter = 1'b1;
              state_nx    = MD_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              if (bus.b == '0) begin
                accept_dbz = 1'b1;
                state_nx   = MD_FINISH;
              end else begin
                accept_iter = 1'b1;
                state_nx    = MD_BUSY;
              end
            end
            MD_MTHI: wr_hi = 1'b1;
            MD_MTLO: wr_lo = 1'b1;
`ifdef MULDIV_MADD_EN
            MD_MADD, MD_MADDU: begin
              accept_iter = 1'b1;
              state_nx    = MD_BUSY;
            end
`endif
            default: wr_nop = 1'b1;
          endcase
        end
      end
      MD_BUSY: begin
        if (bus.flush) begin
          state_nx = MD_IDLE;
        end else begin
          step_en = 1'b1;
          if (last_iter) state_nx = MD_FINISH;
        end
      end
      MD_FINISH: begin
        state_nx  = MD_IDLE;
        finish_wr = !bus.flush;
      end
      default: state_nx = MD_IDLE;
    endcase
  end

  // Operands are held as magnitudes; signs are reapplied at FINISH
  always_ff @(posedge clk) begin
    if (accept_iter) begin
      op_r  <= op_in;
      acc   <= '0;
      q     <= is_div_op(op_in) ? mag(a_s, signed_op) : mag(b_s, signed_op);
      m     <= is_div_op(op_in) ? mag(b_s, signed_op) : mag(a_s, signed_op);
      neg_q <= signed_op & (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
      neg_r <= signed_op & a_s[WIDTH-1];
      dbz_r <= 1'b0;
    end else if (accept_dbz) begin
      op_r  <= op_in;
      acc   <= bus.a;
      q     <= '1;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz_r <= 1'b1;
    end else if (step_en) begin
      acc <= acc_step;
      q   <= q_step;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_op(op_r)),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  assign prod_fix = neg_2w({acc, q}, neg_q);
  assign quot_fix = neg_w(q, neg_q);
  assign rem_fix  = neg_w(acc, neg_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dbz_flag <= 1'b0;
    end else begin
      done     <= finish_wr | wr_hi | wr_lo | wr_nop;
      dbz_flag <= finish_wr & dbz_r;
      if (wr_hi) hi <= bus.a;
      if (wr_lo) lo <= bus.a;
      if (finish_wr) begin
        if (is_div_op(op_r)) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end
`ifdef MULDIV_MADD_EN
        else if (op_r == MD_MADD || op_r == MD_MADDU) begin
          {hi, lo} <= {hi, lo} + prod_fix;
        end
`endif
        else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

  assign bus.ready       = (state == MD_IDLE);
  assign bus.busy        = (state != MD_IDLE);
  assign bus.done        = done;
  assign bus.div_by_zero = dbz_flag;
  assign bus.hi          = hi;
  assign bus.lo          = lo;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed testbench for muldiv_seq_unit at WIDTH=32 (honours MULDIV_MADD_EN).
module tb_muldiv_seq_unit;
  import muldiv_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  muldiv_seq_unit_if #(.WIDTH(W)) bus ();
  muldiv_seq_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // edges: rising edges from the one that samples start up to and including
  // the one after which done is seen (-1 when done never arrives)
  task automatic run_op(input md_op_e op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        output int edges, output bit saw_busy);
    edges = 0;
    saw_busy = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i;
    @(posedge clk); edges = 1;
    @(negedge clk); bus.start = 1'b0;
    while (!bus.done && edges < 200) begin
      saw_busy |= bus.busy;
      @(posedge clk); edges++;
      @(negedge clk);
    end
    if (!bus.done) edges = -1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = MD_MULT; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if ({bus.ready, bus.busy, bus.done, bus.div_by_zero} !== 4'b1000) begin n_bad++; $display("FAIL reset_ctrl got %b want 1000", {bus.ready, bus.busy, bus.done, bus.div_by_zero}); end
    n_vec++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 00000000", bus.hi); end
    n_vec++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 00000000", bus.lo); end
    rst_n = 1'b1;
  endtask

  task automatic test_mt();
    int e; bit sb;
    run_op(MD_MTHI, 32'h12345678, 32'h0, e, sb);
    n_vec++; if (e !== 1 || sb !== 1'b0) begin n_bad++; $display("FAIL mthi_lat got edges=%0d busy=%0d want edges=1 busy=0", e, sb); end
    n_vec++; if (bus.hi !== 32'h12345678) begin n_bad++; $display("FAIL mthi_hi got %h want 12345678", bus.hi); end
    run_op(MD_MTLO, 32'h9ABCDEF0, 32'h0, e, sb);
    n_vec++; if (e !== 1 || sb !== 1'b0) begin n_bad++; $display("FAIL mtlo_lat got edges=%0d busy=%0d want edges=1 busy=0", e, sb); end
    n_vec++; if (bus.hi !== 32'h12345678 || bus.lo !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL mt_hilo got %h:%h want 12345678:9abcdef0", bus.hi, bus.lo); end
  endtask

  task automatic test_flush();
    bit saw_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'hFFFFFFFF; bus.b = 32'h2;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.flush = 1'b0;
    n_vec++; if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin n_bad++; $display("FAIL flush_idle got rdy/busy/done=%b want 100", {bus.ready, bus.busy, bus.done}); end
    repeat (40) begin @(negedge clk); if (bus.done) saw_done = 1'b1; end
    n_vec++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL flush_nodone got done seen=%0d want 0", saw_done); end
    n_vec++; if (bus.hi !== 32'h12345678 || bus.lo !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL flush_hilo got %h:%h want 12345678:9abcdef0", bus.hi, bus.lo); end
  endtask

  task automatic test_flush_in_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MTHI; bus.a = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0; bus.flush = 1'b0;
    n_vec++; if (bus.done !== 1'b0 || bus.hi !== 32'h12345678) begin n_bad++; $display("FAIL flush_drop got done=%0d hi=%h want done=0 hi=12345678", bus.done, bus.hi); end
  endtask

  task automatic test_mult();
    int e; bit sb;
    // accept edge plus 33 more edges
    run_op(MD_MULT, 32'hFFFFFFFD, 32'h00000007, e, sb);
    n_vec++; if (e !== 34 || sb !== 1'b1) begin n_bad++; $display("FAIL mult_lat got edges=%0d busy=%0d want edges=34 busy=1", e, sb); end
    n_vec++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_val got %h:%h want ffffffff:ffffffeb", bus.hi, bus.lo); end
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, e, sb);
    n_vec++; if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_val got %h:%h want fffffffe:00000001", bus.hi, bus.lo); end
  endtask

  task automatic test_div();
    int e; bit sb;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'h00000002, e, sb);
    n_vec++; if (e !== 34) begin n_bad++; $display("FAIL div_lat got edges=%0d want 34", e); end
    n_vec++; if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg got lo=%h hi=%h want lo=fffffffd hi=ffffffff", bus.lo, bus.hi); end
    run_op(MD_DIVU, 32'h7, 32'h2, e, sb);
    n_vec++; if (bus.lo !== 32'h3 || bus.hi !== 32'h1) begin n_bad++; $display("FAIL divu_val got lo=%h hi=%h want lo=00000003 hi=00000001", bus.lo, bus.hi); end
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, e, sb);
    n_vec++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0 || bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL div_min got lo=%h hi=%h dz=%0d want lo=80000000 hi=00000000 dz=0", bus.lo, bus.hi, bus.div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int e; bit sb;
    run_op(MD_DIVU, 32'h5, 32'h0, e, sb);
    n_vec++; if (e !== 2 || bus.div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dbz_lat got edges=%0d dz=%0d want edges=2 dz=1", e, bus.div_by_zero); end
    n_vec++; if (bus.hi !== 32'h5 || bus.lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dbz_val got hi=%h lo=%h want hi=00000005 lo=ffffffff", bus.hi, bus.lo); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dbz_pulse got done=%0d dz=%0d want 0 0", bus.done, bus.div_by_zero); end
  endtask

  task automatic test_ignore_start();
    int e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULT; bus.a = 32'h6; bus.b = 32'h7;
    @(posedge clk); e = 1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) begin @(posedge clk); e++; end
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
    @(posedge clk); e++;
    @(negedge clk); bus.start = 1'b0;
    while (!bus.done && e < 200) begin @(posedge clk); e++; @(negedge clk); end
    n_vec++; if (e !== 34) begin n_bad++; $display("FAIL ignore_lat got edges=%0d want 34", e); end
    n_vec++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0000002A) begin n_bad++; $display("FAIL ignore_val got %h:%h want 00000000:0000002a", bus.hi, bus.lo); end
    @(negedge clk);
    n_vec++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL ignore_noq got rdy=%0d busy=%0d want 1 0", bus.ready, bus.busy); end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_vec++; if ({bus.ready, bus.busy, bus.done, bus.div_by_zero} !== 4'b1000) begin n_bad++; $display("FAIL rstmid_ctrl got %b want 1000", {bus.ready, bus.busy, bus.done, bus.div_by_zero}); end
    n_vec++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin n_bad++; $display("FAIL rstmid_hilo got %h:%h want 00000000:00000000", bus.hi, bus.lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_madd();
    int e; bit sb;
    run_op(MD_MULTU, 32'd10, 32'd1, e, sb);
    n_vec++; if (e !== 34 || bus.hi !== 32'h0 || bus.lo !== 32'd10) begin n_bad++; $display("FAIL multu10 got edges=%0d %h:%h want edges=34 00000000:0000000a", e, bus.hi, bus.lo); end
    run_op(MD_MADD, 32'd3, 32'd4, e, sb);
`ifdef MULDIV_MADD_EN
    n_vec++; if (e !== 34 || bus.hi !== 32'h0 || bus.lo !== 32'd22) begin n_bad++; $display("FAIL madd got edges=%0d %h:%h want edges=34 00000000:00000016", e, bus.hi, bus.lo); end
`else
    n_vec++; if (e !== 1 || sb !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd10) begin n_bad++; $display("FAIL madd_nop got edges=%0d busy=%0d %h:%h want edges=1 busy=0 00000000:0000000a", e, sb, bus.hi, bus.lo); end
`endif
  endtask

  initial begin
    test_reset();
    test_mt();
    test_flush();
    test_flush_in_idle();
    test_mult();
    test_div();
    test_div_by_zero();
    test_ignore_start();
    test_reset_mid_div();
    test_madd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish before 200000ns");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
Parametrised, multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Uses one iterative datapath: shift-add for multiply, restoring division for divide.
- Uses a start/busy/done handshake so the pipeline stalls while an operation is in flight.

Parameters:
- WIDTH, 32: operand/HI/LO width. Must be even and at least 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request; sampled only when ready=1
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU (6/7 only with the optional feature)
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data
- b  in  WIDTH  rt operand: multiplier or divisor
- flush  in  1  abort in-flight operation; pipeline squash
- ready  out  1  unit idle; start will be accepted
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse; HI/LO updated on this same edge
- div_by_zero  out  1  qualifies done for DIV/DIVU with b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): hi=0, lo=0, ready=1, busy=0, done=0, div_by_zero=0, FSM=IDLE, counter=0.
- FSM states: IDLE, BUSY, FINISH.
- IDLE, start with op 0–3 and b!=0 (or any multiply): latch operands, busy=1, go to BUSY. For signed ops, latch magnitudes plus the result signs.
- BUSY: perform one iteration per cycle for WIDTH cycles, then go to FINISH.
- FINISH: apply sign correction, write hi/lo, pulse done=1 for one cycle, return to IDLE.
- Latency: start accepted at edge E; done=1 and hi/lo new in the cycle after edge E+WIDTH+1. For WIDTH=32 that is 33 edges.
- ready = (state==IDLE). busy=1 in BUSY and FINISH.
- A start while not ready is ignored; no queuing.
- Multiply: the 2*WIDTH product goes to {hi,lo}.
  - MULT: two's-complement signed product.
  - MULTU: unsigned product.
- Divide: lo=quotient, hi=remainder.
  - DIV truncates toward zero; the remainder takes the dividend's sign.
  - DIV of MIN by -1: lo=MIN, hi=0, no flag.
- Divide by zero (DIV/DIVU with b==0): skip BUSY and go to FINISH at the next edge. Write hi=a, lo=all ones; done=1 and div_by_zero=1 together. Total latency is 2 edges.
- MTHI/MTLO: accepted in IDLE. Write hi (or lo) at the next edge, pulse done there, never assert busy.
- flush=1 in BUSY or FINISH: go to IDLE at the next edge.
  - hi/lo unchanged, done not pulsed.
  - flush beats the FINISH write.
  - flush in IDLE has no effect, and a same-cycle start is dropped.
- rst_n falling mid-operation: immediate return to reset values.
- Ops 6/7 without the optional feature: treated as NOP. done pulses next edge, hi/lo unchanged.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 6/7 perform {hi,lo} += a*b, signed for 6 and unsigned for 7, modulo 2^(2*WIDTH). Latency is the same as MULT, with one extra adder at FINISH.
- Undefined: ops 6/7 behave as a one-cycle NOP, and no accumulate adder is synthesised.

Decomposition:
- Shared package muldiv_pkg holds the op encodings (MD_MULT..MD_MADDU) and the state enum (MD_IDLE, MD_BUSY, MD_FINISH).
- Sub-module muldiv_step (combinational): one shift-add or restore-subtract iteration on {acc, q}, selected by an is_div input. It is instantiated once.

Test Plan (all at WIDTH=32):
- MULT a=FFFFFFFD, b=00000007: hi=FFFFFFFF, lo=FFFFFFEB; done exactly 33 edges after the start edge. MULTU a=b=FFFFFFFF: hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=2: lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2: lo=3, hi=1. DIV a=80000000, b=FFFFFFFF: lo=80000000, hi=0.
- DIVU a=5, b=0: done and div_by_zero after 2 edges, hi=5, lo=FFFFFFFF.
- Handshake checks:
  - MULT running, second start at cycle 5: ignored, and the first result is correct.
  - flush at cycle 10: no done, hi/lo keep their prior values, ready=1 next cycle.
  - rst_n pulse mid-DIV: all outputs return to reset values.
- MTHI a=12345678 then MTLO a=9ABCDEF0: each gives done after 1 edge with busy=0, ending with hi=12345678, lo=9ABCDEF0.
- MULTU then MADD: MULTU a=10, b=1 gives {hi,lo}=0:10. MADD a=3, b=4 then gives lo=22 and hi=0 with MULDIV_MADD_EN defined, and {hi,lo} unchanged with done after 1 edge without it.
